// File: rtl/skew_tile_buffer_pkg.sv
// Shared defaults, state encoding and a clog2 helper for the skew tile buffer.
package skew_tile_buffer_pkg;

  localparam int ARRAY_W_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_READY  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/skew_lane_delay.sv
// Per-lane delay line carrying {valid,data}; DELAY=0 collapses to a wire.
module skew_lane_delay #(
  parameter int DELAY  = 0,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  generate
    if (DELAY == 0) begin : g_wire
      // Clock and resets are not needed on the zero-delay lane.
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rst, clear};
      assign out_valid   = in_valid;
      assign out_data    = in_data;
    end else begin : g_shift
      logic [DELAY-1:0][DATA_W:0] stage_reg;

      // Shift {valid,data} one stage per cycle; rst/clear flush every stage.
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          stage_reg <= '0;
        end else begin
          stage_reg[0] <= {in_valid, in_data};
          for (int j = 1; j < DELAY; j++) begin
            stage_reg[j] <= stage_reg[j-1];
          end
        end
      end

      assign out_valid = stage_reg[DELAY-1][DATA_W];
      assign out_data  = stage_reg[DELAY-1][DATA_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/skew_tile_buffer.sv
// Tile buffer for the systolic array west edge: loads up to DEPTH vectors,
// then streams them out with lane i delayed by i cycles.
module skew_tile_buffer
  import skew_tile_buffer_pkg::*;
#(
  parameter int ARRAY_W = ARRAY_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ARRAY_W*DATA_W-1:0] in_data,
  input  logic                      in_last,
  input  logic                      start,
  input  logic [ARRAY_W-1:0]        lane_en,
  input  logic                      clear,
  output logic [ARRAY_W*DATA_W-1:0] out_act,
  output logic [ARRAY_W-1:0]        out_lane_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int AW  = clog2_f(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = clog2_f(ARRAY_W) + 1;

  state_t               state_reg, state_next;
  logic [CW-1:0]        wr_cnt_reg, wr_cnt_next;
  logic [CW-1:0]        rd_cnt_reg, rd_cnt_next;
  logic [CW-1:0]        len_reg, len_next;
  logic [DCW-1:0]       drain_cnt_reg, drain_cnt_next;
  logic                 pending_reg, pending_next;
  logic [ARRAY_W-1:0]   lane_en_reg, lane_en_next;
  logic                 done_reg, done_next;

  logic [ARRAY_W*DATA_W-1:0] mem [DEPTH];
  logic [ARRAY_W*DATA_W-1:0] rd_data_reg;
  logic [AW-1:0]             rd_addr;

  logic                      xfer;
  logic                      last_beat;
  logic                      stream_go;
  logic                      stream_valid;
  logic [ARRAY_W-1:0]        skew_valid;
  logic [ARRAY_W*DATA_W-1:0] skew_data;
  logic [ARRAY_W*DATA_W-1:0] act_gated;

  assign in_ready     = (state_reg == ST_IDLE || state_reg == ST_LOAD) && !rst;
  assign xfer         = in_valid && in_ready;
  assign last_beat    = in_last || (wr_cnt_reg == CW'(DEPTH - 1));
  assign stream_go    = (state_reg == ST_READY) && (pending_reg || start);
  assign stream_valid = (state_reg == ST_STREAM);
  assign busy         = (state_reg != ST_IDLE);
  assign done         = done_reg;

  // Read is issued one cycle ahead: READY prefetches vector 0, and STREAM
  // cycle k fetches vector k+1 so rd_data_reg holds vector k during cycle k.
  assign rd_addr = stream_valid ? (rd_cnt_reg[AW-1:0] + AW'(1)) : '0;

  // Tile storage write port.
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[wr_cnt_reg[AW-1:0]] <= in_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rd_data_reg <= mem[rd_addr];
  end

  // Next-state and counter logic.
  always_comb begin
    state_next     = state_reg;
    wr_cnt_next    = wr_cnt_reg;
    rd_cnt_next    = rd_cnt_reg;
    len_next       = len_reg;
    drain_cnt_next = drain_cnt_reg;
    pending_next   = pending_reg;
    lane_en_next   = lane_en_reg;
    done_next      = 1'b0;
    case (state_reg)
      ST_IDLE, ST_LOAD: begin
        if (start) pending_next = 1'b1;
        if (xfer) begin
          wr_cnt_next = wr_cnt_reg + CW'(1);
          state_next  = ST_LOAD;
          if (last_beat) begin
            len_next   = wr_cnt_reg + CW'(1);
            state_next = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (stream_go) begin
          pending_next = 1'b0;
          lane_en_next = lane_en;
          rd_cnt_next  = '0;
          wr_cnt_next  = '0;
          state_next   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        rd_cnt_next = rd_cnt_reg + CW'(1);
        if (rd_cnt_reg == len_reg - CW'(1)) begin
          drain_cnt_next = '0;
          state_next     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_cnt_next = drain_cnt_reg + DCW'(1);
        if (drain_cnt_reg == DCW'(ARRAY_W - 1)) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Control state register; clear behaves exactly like rst.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_reg     <= ST_IDLE;
      wr_cnt_reg    <= '0;
      rd_cnt_reg    <= '0;
      len_reg       <= '0;
      drain_cnt_reg <= '0;
      pending_reg   <= 1'b0;
      lane_en_reg   <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_cnt_reg    <= wr_cnt_next;
      rd_cnt_reg    <= rd_cnt_next;
      len_reg       <= len_next;
      drain_cnt_reg <= drain_cnt_next;
      pending_reg   <= pending_next;
      lane_en_reg   <= lane_en_next;
      done_reg      <= done_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_W; gi++) begin : g_lane
      logic              lane_v;
      logic [DATA_W-1:0] lane_d;

      // Masked or idle lanes inject zeros so no stale data reaches the array.
      assign lane_v = stream_valid & lane_en_reg[gi];
      assign lane_d = lane_v ? rd_data_reg[gi*DATA_W +: DATA_W] : '0;

      skew_lane_delay #(
        .DELAY  (gi),
        .DATA_W (DATA_W)
      ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (lane_v),
        .in_data   (lane_d),
        .out_valid (skew_valid[gi]),
        .out_data  (skew_data[gi*DATA_W +: DATA_W])
      );

      assign act_gated[gi*DATA_W +: DATA_W] =
        skew_valid[gi] ? skew_data[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  // Output register stage shared by all lanes.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      out_act        <= '0;
      out_lane_valid <= '0;
    end else begin
      out_act        <= act_gated;
      out_lane_valid <= skew_valid;
    end
  end

endmodule

// File: tb/tb_skew_tile_buffer.sv
// Self-checking bench: per-cycle comparison against a tile-level model that
// predicts outputs from the stream start cycle and the stored tile.
module tb_skew_tile_buffer;

  localparam int W  = 4;
  localparam int DW = 8;
  localparam int D  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W*DW-1:0] in_data;
  logic            in_last;
  logic            start;
  logic [W-1:0]    lane_en;
  logic            clear;
  logic [W*DW-1:0] out_act;
  logic [W-1:0]    out_lane_valid;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  skew_tile_buffer #(.ARRAY_W(W), .DATA_W(DW), .DEPTH(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .start          (start),
    .lane_en        (lane_en),
    .clear          (clear),
    .out_act        (out_act),
    .out_lane_valid (out_lane_valid),
    .busy           (busy),
    .done           (done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int n_acc   = 0;

  // Model: phase 0 idle, 1 loading, 2 tile ready, 3 streaming/draining.
  int              m_phase;
  logic [W*DW-1:0] m_tile [D];
  int              m_cnt;
  int              m_len;
  int              m_s;
  int              m_done_at;
  bit              m_pending;
  bit              m_live;
  logic [W-1:0]    m_mask;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_cnt     = 0;
    m_pending = 0;
    m_live    = 0;
    m_done_at = -1;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    if (rst || clear) begin
      model_reset();
    end else begin
      case (m_phase)
        0, 1: begin
          if (start) m_pending = 1;
          if (in_valid) begin
            m_tile[m_cnt] = in_data;
            m_cnt++;
            m_phase = 1;
            if (in_last || m_cnt == D) begin
              m_len   = m_cnt;
              m_phase = 2;
            end
          end
        end
        2: begin
          if (m_pending || start) begin
            m_phase   = 3;
            m_pending = 0;
            m_cnt     = 0;
            m_s       = cyc_n + 1;
            m_mask    = lane_en;
            m_live    = 1;
            m_done_at = m_s + m_len + W;
            $display("[TB] cycle %0d: tile len=%0d mask=%b streams from cycle %0d, done expected at %0d",
                     cyc_n, m_len, lane_en, m_s, m_done_at);
          end
        end
        default: begin
          if (cyc_n + 1 == m_done_at) begin
            m_phase = 0;
            m_live  = 0;
          end
        end
      endcase
    end
  endtask

  // One clock: compare outputs mid-cycle, then step the model at the edge.
  task automatic cyc();
    logic [W*DW-1:0] ea;
    logic [W-1:0]    ev;
    int              k;
    @(negedge clk);
    ea = '0;
    ev = '0;
    for (int i = 0; i < W; i++) begin
      k = cyc_n - m_s - 1 - i;
      if (m_live && k >= 0 && k < m_len && m_mask[i]) begin
        ev[i] = 1'b1;
        ea[i*DW +: DW] = m_tile[k][i*DW +: DW];
      end
    end
    check("in_ready", 64'(in_ready), 64'((m_phase <= 1) && !rst));
    check("busy", 64'(busy), 64'(m_phase != 0));
    check("done", 64'(done), 64'(cyc_n == m_done_at));
    check("lane_valid", 64'(out_lane_valid), 64'(ev));
    check("out_act", 64'(out_act), 64'(ea));
    if (in_valid && in_ready) n_acc++;
    @(posedge clk);
    model_step();
    cyc_n++;
    #1;
  endtask

  task automatic idle_inputs();
    rst      = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    start    = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Drive n back-to-back beats; pattern=1 gives lane i of vector k = 16*k+i.
  task automatic load_tile(input int n, input bit with_last, input bit pattern);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      for (int i = 0; i < W; i++) begin
        in_data[i*DW +: DW] = pattern ? DW'(16 * k + i) : DW'($urandom);
      end
      in_last = with_last && (k == n - 1);
      cyc();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    idle_inputs();
    lane_en = '1;
    m_s     = 0;
    m_len   = 0;
    m_mask  = '0;
    model_reset();

    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2);
    $display("[TB] reset checked");

    // Full tile, all lanes.
    load_tile(8, 1'b1, 1'b1);
    start_pulse();
    wait_cycles(14);
    $display("[TB] full tile finished at cycle %0d", cyc_n);

    // Short tile with start held for the whole transaction.
    start = 1'b1;
    load_tile(3, 1'b1, 1'b0);
    wait_cycles(10);
    start = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    wait_cycles(2);
    $display("[TB] short tile finished at cycle %0d", cyc_n);

    // Overflow guard: nine beats, no in_last.
    n_acc = 0;
    load_tile(9, 1'b0, 1'b0);
    check("ovf_accepted", 64'(n_acc), 64'(D));
    start_pulse();
    wait_cycles(14);
    $display("[TB] overflow tile finished at cycle %0d", cyc_n);

    // Masked lanes.
    lane_en = 4'b1010;
    load_tile(8, 1'b1, 1'b1);
    start_pulse();
    lane_en = 4'b1111;
    wait_cycles(14);
    $display("[TB] masked tile finished at cycle %0d", cyc_n);

    // Clear during STREAM at rd_cnt = 4, then a fresh tile.
    load_tile(8, 1'b1, 1'b0);
    start_pulse();
    wait_cycles(4);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    wait_cycles(3);
    load_tile(5, 1'b1, 1'b0);
    start_pulse();
    wait_cycles(11);
    $display("[TB] clear/reload finished at cycle %0d", cyc_n);

    // Reset part-way through a load; start alone must not stream.
    load_tile(5, 1'b0, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    start_pulse();
    wait_cycles(5);
    load_tile(4, 1'b1, 1'b0);
    wait_cycles(12);
    $display("[TB] reset-in-load finished at cycle %0d", cyc_n);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = W*DW'($urandom);
      in_last  = ($urandom_range(0, 4) == 0);
      start    = ($urandom_range(0, 5) == 0);
      lane_en  = W'($urandom);
      clear    = ($urandom_range(0, 150) == 0);
      rst      = ($urandom_range(0, 400) == 0);
      cyc();
    end
    idle_inputs();
    wait_cycles(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
